// File: rtl/sdr_qsram_pipelined.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sdr_qsram_pipelined
// Description : Single-port synchronous SRAM with pipelined read and refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module sdr_qsram_pipelined #(
    parameter int unsigned ADDR_WIDTH       = 8,
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned READ_LATENCY     = 2,
    parameter int unsigned REFRESH_INTERVAL = 64,
    parameter int unsigned REFRESH_CYCLES   = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Read,
    input  logic                  Write,
    input  logic                  Refresh,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Ready,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  RefreshBusy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned TW    = $clog2(REFRESH_INTERVAL);
    localparam int unsigned CW    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [TW-1:0] C_TIMER_LAST = TW'(REFRESH_INTERVAL - 1);
    localparam logic [CW-1:0] C_CNT_LOAD   = CW'(REFRESH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_REFRESH = 1'b1
    } state_t;

    state_t                                   state_q, state_d;
    logic [TW-1:0]                            timer_q, timer_d;
    logic [CW-1:0]                            rcnt_q, rcnt_d;
    logic                                     busy_q, busy_d;
    logic [READ_LATENCY-1:0]                  vld_q, vld_d;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]  dat_q, dat_d;
    logic [DATA_WIDTH-1:0]                    mem_q [DEPTH];

    logic cmd_ok;
    logic rd_acc;
    logic wr_acc;
    logic refresh_req;

    assign Ready       = (state_q == ST_IDLE);
    assign cmd_ok      = Ready & Enable & ~Reset;
    assign rd_acc      = cmd_ok & Read;
    assign wr_acc      = cmd_ok & Write;
    assign refresh_req = Refresh | (timer_q == C_TIMER_LAST);

    assign ReadValid   = vld_q[READ_LATENCY-1];
    assign ReadData    = dat_q[READ_LATENCY-1];
    assign RefreshBusy = busy_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rcnt_d  = rcnt_q;

        case (state_q)
            ST_IDLE: begin
                timer_d = timer_q + 1'b1;
                if (refresh_req) begin
                    state_d = ST_REFRESH;
                    timer_d = '0;
                    rcnt_d  = C_CNT_LOAD;
                end
            end
            ST_REFRESH: begin
                timer_d = '0;
                if (rcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_REFRESH);
    end

    // Each data stage only loads when a valid word moves into it, so the
    // output word holds between strobes. The array read is taken before the
    // same-edge write lands, giving read-before-write.
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = rd_acc;
        if (rd_acc) begin
            dat_d[0] = mem_q[Address];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            rcnt_q  <= '0;
            busy_q  <= 1'b0;
            vld_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rcnt_q  <= rcnt_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clock) begin
        if (wr_acc) begin
            mem_q[Address] <= WriteData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdr_qsram_pipelined.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdr_qsram_pipelined
// Description : Directed self-checking bench for sdr_qsram_pipelined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdr_qsram_pipelined;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          Clock     = 1'b0;
    logic          Reset     = 1'b1;
    logic          Enable    = 1'b0;
    logic          Read      = 1'b0;
    logic          Write     = 1'b0;
    logic          Refresh   = 1'b0;
    logic [AW-1:0] Address   = '0;
    logic [DW-1:0] WriteData = '0;
    logic          Ready;
    logic [DW-1:0] ReadData;
    logic          ReadValid;
    logic          RefreshBusy;

    int total  = 0;
    int passed = 0;
    int n      = 0;

    logic [DW-1:0] exp_mem [8];

    sdr_qsram_pipelined #(
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .READ_LATENCY     (2),
        .REFRESH_INTERVAL (64),
        .REFRESH_CYCLES   (4)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .Read        (Read),
        .Write       (Write),
        .Refresh     (Refresh),
        .Address     (Address),
        .WriteData   (WriteData),
        .Ready       (Ready),
        .ReadData    (ReadData),
        .ReadValid   (ReadValid),
        .RefreshBusy (RefreshBusy)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clock);
        #1;
        n++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        Enable  = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Refresh = 1'b0;
        tick();
        tick();
        check("rst_ready", Ready, 1);
        check("rst_valid", ReadValid, 0);
        check("rst_busy", RefreshBusy, 0);
        check("rst_rdata", ReadData, 0);
        Reset = 1'b0;
        n     = 0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        Enable    = 1'b1;
        Write     = 1'b1;
        Read      = 1'b0;
        Address   = a;
        WriteData = d;
        tick();
        Enable = 1'b0;
        Write  = 1'b0;
    endtask

    initial begin
        logic          exp_busy;
        logic          take;
        logic          ev0, ev1;
        logic [DW-1:0] ed0, ed1;
        int            acc, stalls, got;

        // Idle automatic refresh: 64 IDLE cycles then 4 REFRESH, repeating.
        do_reset();
        for (int k = 1; k <= 140; k++) begin
            tick();
            exp_busy = ((k % 68) >= 64);
            check("auto_busy", RefreshBusy, exp_busy);
            check("auto_ready", Ready, !exp_busy);
        end

        // Write then read back with two-edge latency.
        do_reset();
        wr(8'h10, 16'hA5A5);
        Enable = 1'b1; Read = 1'b1; Address = 8'h10;
        tick();
        Enable = 1'b0; Read = 1'b0;
        check("t1_valid_early", ReadValid, 0);
        tick();
        check("t1_valid", ReadValid, 1);
        check("t1_data", ReadData, 16'hA5A5);
        tick();
        check("t1_valid_after", ReadValid, 0);
        check("t1_data_hold", ReadData, 16'hA5A5);

        // Read-before-write on a simultaneous command, new data next cycle.
        wr(8'h20, 16'h1111);
        Enable = 1'b1; Read = 1'b1; Write = 1'b1; Address = 8'h20; WriteData = 16'h2222;
        tick();
        Write = 1'b0;
        tick();
        check("t2_rbw_valid", ReadValid, 1);
        check("t2_rbw_data", ReadData, 16'h1111);
        Enable = 1'b0; Read = 1'b0;
        tick();
        check("t2_new_valid", ReadValid, 1);
        check("t2_new_data", ReadData, 16'h2222);
        tick();
        check("t2_idle_valid", ReadValid, 0);

        // External refresh pulse together with an accepted read.
        do_reset();
        wr(8'h05, 16'h0BEE);
        check("t4_ready_pre", Ready, 1);
        Enable = 1'b1; Read = 1'b1; Address = 8'h05; Refresh = 1'b1;
        tick();
        Enable = 1'b0; Read = 1'b0; Refresh = 1'b0;
        check("t4_ready_r1", Ready, 0);
        check("t4_busy_r1", RefreshBusy, 1);
        check("t4_valid_r1", ReadValid, 0);
        Refresh = 1'b1;
        tick();
        Refresh = 1'b0;
        check("t4_valid", ReadValid, 1);
        check("t4_data", ReadData, 16'h0BEE);
        check("t4_ready_r2", Ready, 0);
        tick();
        check("t4_ready_r3", Ready, 0);
        check("t4_valid_r3", ReadValid, 0);
        tick();
        check("t4_ready_r4", Ready, 0);
        tick();
        check("t4_ready_back", Ready, 1);
        check("t4_busy_back", RefreshBusy, 0);

        // Continuous reads of 0..7 across the first automatic refresh.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_mem[i] = 16'h5A00 + 16'(i);
            wr(AW'(i), exp_mem[i]);
        end
        while (n < 60) tick();
        acc = 0; stalls = 0; got = 0;
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        for (int it = 0; it < 40; it++) begin
            take = 1'b0;
            if (acc < 8) begin
                Enable  = 1'b1;
                Read    = 1'b1;
                Address = AW'(acc);
                take    = Ready;
                if (!Ready) stalls++;
            end else begin
                Enable = 1'b0;
                Read   = 1'b0;
            end
            tick();
            ev1 = ev0;
            ed1 = ed0;
            ev0 = take;
            ed0 = (acc < 8) ? exp_mem[acc] : '0;
            if (take) acc++;
            check("t5_valid", ReadValid, ev1);
            if (ev1) begin
                check("t5_data", ReadData, ed1);
                got++;
            end
        end
        check("t5_accepted", acc, 8);
        check("t5_returned", got, 8);
        check("t5_stalls", stalls, 4);

        // Reset during refresh discards the in-flight read and restarts the timer.
        do_reset();
        Enable = 1'b1; Read = 1'b1; Address = 8'h03; Refresh = 1'b1;
        tick();
        Enable = 1'b0; Read = 1'b0; Refresh = 1'b0;
        check("t6_busy_in", RefreshBusy, 1);
        Reset = 1'b1;
        tick();
        check("t6_valid_rst", ReadValid, 0);
        check("t6_ready_rst", Ready, 1);
        check("t6_busy_rst", RefreshBusy, 0);
        Reset = 1'b0;
        n = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            check("t6_no_valid", ReadValid, 0);
            check("t6_timer_busy", RefreshBusy, (k == 64));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
